vga_plot_sink: RTL

//  Receiving end of the object plot stream: accepts (x, y, colour, plot) pixel writes from two sprite

---
 rtl/vga_plot_sink.sv | 132 +++++++++++++
 1 files changed

// File: rtl/vga_plot_sink.sv
// ---------------------------------------------------------------------------
// vga_plot_sink
//
// Receiving end of the object plot stream. Two sprite drawers push pixel
// writes (x, y, colour) into a small FIFO; the FIFO is replayed one pixel
// per cycle onto the VGA adapter write port whenever out_enable is high.
// Producers get a combinational ready; a producer that plots while not
// ready loses that pixel and raises the sticky dropped flag.
//
// Ports:
//   CLOCK_50      system clock, single domain
//   rst           asynchronous active-high reset
//   p0_plot/x/y/color, p0_ready   pixel write port 0 (favoured after reset)
//   p1_plot/x/y/color, p1_ready   pixel write port 1
//   out_enable    1 = drain one pixel per cycle, 0 = hold
//   clear_drop    synchronous clear of dropped (a same-cycle drop wins)
//   VGA_X/Y/COLOR registered pixel to the adapter
//   VGA_PLOT      one-cycle write strobe per replayed pixel
//   fifo_count    entries currently stored (0..DEPTH)
//   dropped       sticky: a request was refused since the last clear
// ---------------------------------------------------------------------------
module vga_plot_sink #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          p0_plot,
    input  logic [8:0]    p0_x,
    input  logic [7:0]    p0_y,
    input  logic [2:0]    p0_color,
    output logic          p0_ready,
    input  logic          p1_plot,
    input  logic [8:0]    p1_x,
    input  logic [7:0]    p1_y,
    input  logic [2:0]    p1_color,
    output logic          p1_ready,
    input  logic          out_enable,
    input  logic          clear_drop,
    output logic [8:0]    VGA_X,
    output logic [7:0]    VGA_Y,
    output logic [2:0]    VGA_COLOR,
    output logic          VGA_PLOT,
    output logic [AW:0]   fifo_count,
    output logic          dropped
);

    localparam int          PIX_W   = 9 + 8 + 3;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    p1_slot;
    logic             rr;
    logic [AW:0]      free;
    logic             free_many;
    logic             free_one;
    logic             push0;
    logic             push1;
    logic             pop;
    logic             drop_now;

    // Free space is judged on the registered count only, so a pop at this
    // edge never lends its slot to a push at the same edge. With a single
    // slot left and both ports asking, rr picks the winner; a lone
    // requester always gets the slot.
    always_comb begin
        free      = DEPTH_C - fifo_count;
        free_many = free >= (AW+1)'(2);
        free_one  = free == (AW+1)'(1);
        p0_ready  = free_many | (free_one & (~p1_plot | ~rr));
        p1_ready  = free_many | (free_one & (~p0_plot |  rr));
        push0     = p0_plot & p0_ready;
        push1     = p1_plot & p1_ready;
        pop       = out_enable & (fifo_count != '0);
        drop_now  = (p0_plot & ~p0_ready) | (p1_plot & ~p1_ready);
        // Port 0 is ordered first when both ports are accepted together.
        p1_slot   = push0 ? wr_ptr + AW'(1) : wr_ptr;
    end

    // Pixel storage has no reset: contents are only read when counted valid.
    // Writes and the read never touch the same slot at one edge because a
    // full FIFO accepts no pushes.
    always_ff @(posedge CLOCK_50) begin
        if (push0) begin
            mem[wr_ptr] <= {p0_x, p0_y, p0_color};
        end
        if (push1) begin
            mem[p1_slot] <= {p1_x, p1_y, p1_color};
        end
    end

    // Pointers, count, arbitration state, output register and drop flag.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr         <= 1'b0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOR  <= '0;
            VGA_PLOT   <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push0) + AW'(push1);
            fifo_count <= fifo_count + (AW+1)'(push0) + (AW+1)'(push1)
                          - (AW+1)'(pop);

            if (free_one && p0_plot && p1_plot) begin
                rr <= ~rr;
            end

            if (pop) begin
                {VGA_X, VGA_Y, VGA_COLOR} <= mem[rd_ptr];
                VGA_PLOT <= 1'b1;
                rd_ptr   <= rd_ptr + AW'(1);
            end else begin
                VGA_PLOT <= 1'b0;
            end

            if (drop_now) begin
                dropped <= 1'b1;
            end else if (clear_drop) begin
                dropped <= 1'b0;
            end
        end
    end

endmodule
